// File: rtl/mult_pkg.sv
// Shared definitions for the iterative shift-add multiplier: FSM encoding
// and operand-width limits.
package mult_pkg;

  localparam int DEFAULT_W = 8;
  localparam int W_MIN     = 2;
  localparam int W_MAX     = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/shift_add_datapath.sv
// Radix-2 shift-add datapath: operates on operand magnitudes, then applies
// the sign fix-up as the final product is written to p.
module shift_add_datapath
  import mult_pkg::*;
#(
  parameter int W = DEFAULT_W
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           load,
  input  logic           step,
  input  logic           finish,
  input  logic           is_signed,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic [2*W-1:0] p
);

  logic [W-1:0]   mcand;
  logic [2*W-1:0] acc;
  logic           neg;

  logic [W-1:0]   mag_a;
  logic [W-1:0]   mag_b;
  logic [W:0]     sum;
  logic [2*W-1:0] acc_step;
  logic [2*W-1:0] product_fix;

  // The multiplier lives in the low half of acc and shifts out as the
  // partial product shifts in, so no separate multiplier register is needed.
  always_comb begin
    mag_a       = (is_signed && a[W-1]) ? -a : a;
    mag_b       = (is_signed && b[W-1]) ? -b : b;
    sum         = {1'b0, acc[2*W-1:W]} + {1'b0, mcand};
    acc_step    = acc[0] ? {sum, acc[W-1:1]} : {1'b0, acc[2*W-1:1]};
    product_fix = neg ? -acc_step : acc_step;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand <= '0;
      acc   <= '0;
      neg   <= 1'b0;
      p     <= '0;
    end else begin
      if (load) begin
        mcand <= mag_a;
        acc   <= {{W{1'b0}}, mag_b};
        neg   <= is_signed & (a[W-1] ^ b[W-1]);
      end else if (step) begin
        acc <= acc_step;
      end
      if (finish) begin
        p <= product_fix;
      end
    end
  end

endmodule

// File: rtl/iterative_array_multiplier.sv
// Iterative W-cycle multiplier: FSM and step counter around the shift-add
// datapath; one product every W+1 cycles when starts are back to back.
module iterative_array_multiplier
  import mult_pkg::*;
#(
  parameter int W = DEFAULT_W
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic           is_signed,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic           busy,
  output logic           done,
  output logic [2*W-1:0] p
);

  localparam int CW = $clog2(W);
  localparam logic [CW-1:0] LAST = CW'(W - 1);

  if (W < W_MIN || W > W_MAX) begin : g_bad_width
    $error("iterative_array_multiplier: W out of range");
  end

  state_t        state;
  state_t        next_state;
  logic [CW-1:0] cnt;
  logic          last;
  logic          load;
  logic          step;
  logic          finish;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // A start seen in DONE chains straight into the next run with no idle gap.
  always_comb begin
    next_state = state;
    load       = 1'b0;
    step       = 1'b0;
    finish     = 1'b0;
    last       = (cnt == LAST);
    case (state)
      IDLE, DONE: begin
        if (start) begin
          load       = 1'b1;
          next_state = BUSY;
        end else begin
          next_state = IDLE;
        end
      end
      BUSY: begin
        step = 1'b1;
        if (last) begin
          finish     = 1'b1;
          next_state = DONE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= '0;
    end else if (state == BUSY && !last) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign busy = (state == BUSY);
  assign done = (state == DONE);

  shift_add_datapath #(.W(W)) u_datapath (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (load),
    .step      (step),
    .finish    (finish),
    .is_signed (is_signed),
    .a         (a),
    .b         (b),
    .p         (p)
  );

endmodule

// File: tb/tb_iterative_array_multiplier.sv
// Self-checking bench for iterative_array_multiplier at W=8 and W=16,
// using directed products plus randomized operands against an arithmetic model.
module tb_iterative_array_multiplier;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic        start;
  logic        is_signed;
  logic [7:0]  a;
  logic [7:0]  b;
  logic        busy;
  logic        done;
  logic [15:0] p;

  logic        start16;
  logic        is_signed16;
  logic [15:0] a16;
  logic [15:0] b16;
  logic        busy16;
  logic        done16;
  logic [31:0] p16;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  iterative_array_multiplier #(.W(8)) dut8 (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .is_signed (is_signed),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .done      (done),
    .p         (p)
  );

  iterative_array_multiplier #(.W(16)) dut16 (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start16),
    .is_signed (is_signed16),
    .a         (a16),
    .b         (b16),
    .busy      (busy16),
    .done      (done16),
    .p         (p16)
  );

  function automatic logic [15:0] refMult8(input logic [7:0] x, input logic [7:0] y,
                                           input logic s);
    int xi;
    int yi;
    xi = s ? int'($signed(x)) : int'(x);
    yi = s ? int'($signed(y)) : int'(y);
    return 16'(xi * yi);
  endfunction

  function automatic logic [31:0] refMult16(input logic [15:0] x, input logic [15:0] y,
                                            input logic s);
    longint xi;
    longint yi;
    xi = s ? longint'($signed(x)) : longint'(x);
    yi = s ? longint'($signed(y)) : longint'(y);
    return 32'(xi * yi);
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
    checks++;
    assert (got === exp)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic nextEdge();
    @(posedge clk);
    #1;
  endtask

  // Issues one start and follows it until done; optionally scrambles the
  // operand inputs and pulses a spurious start while busy.
  task automatic applyStimulus(input logic [7:0] ia, input logic [7:0] ib,
                               input logic is_s, input bit toggle, input int pulse_at,
                               output logic [15:0] got, output int edges,
                               output int busy_cycles, output bit held);
    logic [15:0] prev_p;
    prev_p = p;
    held = 1'b1;
    a = ia;
    b = ib;
    is_signed = is_s;
    start = 1'b1;
    nextEdge();
    edges = 1;
    busy_cycles = 0;
    start = 1'b0;
    while (!done && edges < 40) begin
      if (busy) busy_cycles++;
      if (p !== prev_p) held = 1'b0;
      if (toggle) begin
        a = 8'($urandom);
        b = 8'($urandom);
        is_signed = 1'($urandom);
      end
      start = (pulse_at != 0 && busy_cycles == pulse_at);
      if (start) begin
        a = ~ia;
        b = ib + 8'd1;
      end
      nextEdge();
      edges++;
    end
    start = 1'b0;
    got = p;
  endtask

  task automatic runCheck(input string tag, input logic [7:0] ia, input logic [7:0] ib,
                          input logic is_s, input bit toggle, input int pulse_at,
                          input logic [15:0] exp);
    logic [15:0] got;
    int          edges;
    int          busy_cycles;
    bit          held;
    applyStimulus(ia, ib, is_s, toggle, pulse_at, got, edges, busy_cycles, held);
    checkOutput({tag, "_p"}, 32'(got), 32'(exp));
    checkOutput({tag, "_latency"}, 32'(edges), 32'd9);
    checkOutput({tag, "_busy_cycles"}, 32'(busy_cycles), 32'd8);
    checkOutput({tag, "_p_hold"}, 32'(held), 32'd1);
  endtask

  task automatic run16(input string tag, input logic [15:0] ia, input logic [15:0] ib,
                       input logic is_s, input logic [31:0] exp);
    int edges;
    a16 = ia;
    b16 = ib;
    is_signed16 = is_s;
    start16 = 1'b1;
    nextEdge();
    edges = 1;
    start16 = 1'b0;
    while (!done16 && edges < 60) begin
      nextEdge();
      edges++;
    end
    checkOutput({tag, "_p"}, p16, exp);
    checkOutput({tag, "_latency"}, 32'(edges), 32'd17);
    checkOutput({tag, "_model"}, p16, refMult16(ia, ib, is_s));
  endtask

  initial begin
    logic [7:0] ra;
    logic [7:0] rb;
    logic       rs;
    int         done_count;
    int         busy_count;

    start = 1'b0;
    is_signed = 1'b0;
    a = '0;
    b = '0;
    start16 = 1'b0;
    is_signed16 = 1'b0;
    a16 = '0;
    b16 = '0;

    #12;
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_done", 32'(done), 32'd0);
    checkOutput("reset_p", 32'(p), 32'd0);
    checkOutput("reset_p16", p16, 32'd0);

    @(negedge clk);
    rst_n = 1'b1;
    nextEdge();
    nextEdge();
    checkOutput("idle_done", 32'(done), 32'd0);

    $display("[TB] unsigned back-to-back products");
    runCheck("u_1x9", 8'd1, 8'd9, 1'b0, 1'b0, 0, 16'd9);
    runCheck("u_5x10", 8'd5, 8'd10, 1'b0, 1'b0, 0, 16'd50);
    runCheck("u_26x3", 8'h26, 8'd3, 1'b0, 1'b0, 0, 16'd114);
    runCheck("u_24x37", 8'h24, 8'h37, 1'b0, 1'b0, 0, 16'd1980);
    nextEdge();
    checkOutput("done_single_pulse", 32'(done), 32'd0);
    checkOutput("p_hold_idle", 32'(p), 32'd1980);

    $display("[TB] signed products");
    runCheck("s_m3x5", 8'hFD, 8'd5, 1'b1, 1'b0, 0, 16'hFFF1);
    runCheck("s_m128xm128", 8'h80, 8'h80, 1'b1, 1'b0, 0, 16'h4000);
    runCheck("s_m128x127", 8'h80, 8'h7F, 1'b1, 1'b0, 0, 16'hC080);
    runCheck("s_127x127", 8'h7F, 8'h7F, 1'b1, 1'b0, 0, 16'h3F01);

    $display("[TB] start pulsed while busy");
    runCheck("busy_start_ignored", 8'd77, 8'd13, 1'b0, 1'b0, 3, 16'd1001);

    $display("[TB] randomized operands with inputs toggling while busy");
    for (int i = 0; i < 12; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      rs = 1'($urandom);
      runCheck("random", ra, rb, rs, 1'b1, 0, refMult8(ra, rb, rs));
      if (($urandom & 1) == 0) nextEdge();
    end

    $display("[TB] zero operands");
    runCheck("zero_a_signed", 8'd0, 8'hAB, 1'b1, 1'b0, 0, 16'd0);
    runCheck("zero_b_signed", 8'h80, 8'd0, 1'b1, 1'b0, 0, 16'd0);
    runCheck("u_255x255", 8'hFF, 8'hFF, 1'b0, 1'b0, 0, 16'hFE01);
    nextEdge();

    $display("[TB] reset during busy");
    a = 8'd200;
    b = 8'd3;
    is_signed = 1'b0;
    start = 1'b1;
    nextEdge();
    start = 1'b0;
    repeat (3) nextEdge();
    checkOutput("pre_reset_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("abort_busy", 32'(busy), 32'd0);
    checkOutput("abort_done", 32'(done), 32'd0);
    checkOutput("abort_p", 32'(p), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    done_count = 0;
    busy_count = 0;
    for (int i = 0; i < 20; i++) begin
      nextEdge();
      if (done) done_count++;
      if (busy) busy_count++;
    end
    checkOutput("no_done_after_reset", 32'(done_count), 32'd0);
    checkOutput("no_busy_after_reset", 32'(busy_count), 32'd0);

    $display("[TB] W=16 products");
    run16("w16_unsigned", 16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE0001);
    run16("w16_signed", 16'hFFFF, 16'hFFFF, 1'b1, 32'd1);
    run16("w16_mixed", 16'h8000, 16'h0003, 1'b1, 32'hFFFE8000);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
